// File: rtl/debug_reg_dump.sv
//==============================================================================
// Module      : debug_reg_dump
// Description : Walks the core's debug register port x0..x(NUM_REGS-1) on a
//               start pulse and streams each sampled word over valid/ready.
//               Define DEBUG_DUMP_PC_EN to append a snapshot of pc_in as a
//               final word with index NUM_REGS.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debug_reg_dump #(
    parameter int NUM_REGS      = 32,
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [4:0]        dbg_sel,
    input  logic [DATA_W-1:0] dbg_data,
    input  logic [31:0]       pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    localparam logic [3:0] c_SETTLE   = SETTLE_CYCLES[3:0];
    localparam logic [4:0] c_LAST_SEL = 5'(NUM_REGS - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [4:0]        r_sel, w_sel_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [5:0]        r_idx, w_idx_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_reg_is_last;

`ifdef DEBUG_DUMP_PC_EN
    localparam logic [5:0] c_PC_IDX = 6'(NUM_REGS);

    logic [31:0]       r_pc, w_pc_nxt;
    logic              r_pc_pend, w_pc_pend_nxt;

    // The PC word closes the dump, so register words never carry out_last.
    assign w_reg_is_last = 1'b0;
`else
    logic              w_unused_pc;

    assign w_unused_pc   = ^pc_in;
    assign w_reg_is_last = (r_sel == c_LAST_SEL);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_data    <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DEBUG_DUMP_PC_EN
            r_pc      <= '0;
            r_pc_pend <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_data    <= w_data_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef DEBUG_DUMP_PC_EN
            r_pc      <= w_pc_nxt;
            r_pc_pend <= w_pc_pend_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = r_sel;
        w_data_nxt    = r_data;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
`ifdef DEBUG_DUMP_PC_EN
        w_pc_nxt      = r_pc;
        w_pc_pend_nxt = r_pc_pend;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = c_SETTLE;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETTLE;
`ifdef DEBUG_DUMP_PC_EN
                    w_pc_nxt    = pc_in;
`endif
                end
            end
            S_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_data_nxt  = dbg_data;
                    w_idx_nxt   = {1'b0, r_sel};
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = w_reg_is_last;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
`ifdef DEBUG_DUMP_PC_EN
                // One idle cycle after the last register word, then the PC word.
                if (r_pc_pend) begin
                    w_data_nxt    = DATA_W'(r_pc);
                    w_idx_nxt     = c_PC_IDX;
                    w_last_nxt    = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_pc_pend_nxt = 1'b0;
                end else
`endif
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_last) begin
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
`ifdef DEBUG_DUMP_PC_EN
                    else if (r_sel == c_LAST_SEL) begin
                        w_pc_pend_nxt = 1'b1;
                    end
`endif
                    else begin
                        w_sel_nxt   = r_sel + 5'd1;
                        w_cnt_nxt   = c_SETTLE;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dbg_sel   = r_sel;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire
